// File: rtl/frame_sched_pkg.sv
// Shared types and defaults for the frame write scheduler.
// State typedef, default parameter values and the channel-index width helper.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DEF_WI      = 32;
  localparam int DEF_WIDTH   = 128;
  localparam int DEF_HEIGHT  = 128;
  localparam int DEF_N_REQ   = 4;
  localparam int DEF_GAP     = 2;
  localparam int DEF_TIMEOUT = 1024;
  localparam int POS_W       = 12;

  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_write_scheduler_rr_arbiter.sv
// Round-robin channel picker: first asserted request at or after ptr.
module rr_arbiter
  import frame_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int CHW   = chw(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [CHW-1:0]   ptr,
  output logic [CHW-1:0]   gnt_idx,
  output logic             any_req
);

  logic           found;
  logic [CHW-1:0] idx;
  int             s;

  always_comb begin
    gnt_idx = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = '0;
    s       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      s = int'(ptr) + k;
      if (s >= N_REQ) s = s - N_REQ;
      idx = CHW'(s);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/frame_write_scheduler.sv
// Grants whole frames to one of N_REQ channels and forwards beats with row/col tags.
// Optional stall timeout enabled by defining FRAME_SCHED_TIMEOUT_EN.
module frame_write_scheduler
  import frame_sched_pkg::*;
#(
  parameter int WI      = DEF_WI,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int N_REQ   = DEF_N_REQ,
  parameter int GAP     = DEF_GAP,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*WI-1:0]         req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        wr_vld,
  output logic [WI-1:0]               wr_data,
  output logic [chw(N_REQ)-1:0]       wr_ch,
  output logic [POS_W-1:0]            wr_row,
  output logic [POS_W-1:0]            wr_col,
  output logic                        frame_start,
  output logic                        frame_done,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int CHW   = chw(N_REQ);
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;

  state_t             state;
  logic [CHW-1:0]     ptr, g, nxt_ptr, arb_idx;
  logic               arb_any;
  logic [POS_W-1:0]   row, col;
  logic [CW-1:0]      cnt;
  logic [GW-1:0]      gap_cnt;
  logic               fire, last;

  rr_arbiter #(.N_REQ(N_REQ), .CHW(CHW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  assign fire    = (state == XFER) && req_valid[g];
  assign last    = (cnt == CW'(TOTAL - 1));
  assign nxt_ptr = (g == CHW'(N_REQ - 1)) ? '0 : g + 1'b1;
  assign busy    = (state == XFER);

  always_comb begin
    req_ready = '0;
    if (state == XFER) req_ready[g] = 1'b1;
  end

`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_cnt;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      ptr         <= '0;
      g           <= '0;
      row         <= '0;
      col         <= '0;
      cnt         <= '0;
      gap_cnt     <= '0;
      wr_vld      <= 1'b0;
      wr_data     <= '0;
      wr_ch       <= '0;
      wr_row      <= '0;
      wr_col      <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
`ifdef FRAME_SCHED_TIMEOUT_EN
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      wr_vld      <= 1'b0;
`ifdef FRAME_SCHED_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (arb_any) begin
            g           <= arb_idx;
            state       <= XFER;
            frame_start <= 1'b1;
            row         <= '0;
            col         <= '0;
            cnt         <= '0;
`ifdef FRAME_SCHED_TIMEOUT_EN
            stall_cnt   <= '0;
`endif
          end
        end
        XFER: begin
          if (fire) begin
            wr_vld  <= 1'b1;
            wr_data <= req_data[int'(g)*WI +: WI];
            wr_ch   <= g;
            wr_row  <= row;
            wr_col  <= col;
            cnt     <= cnt + 1'b1;
            if (col == POS_W'(WIDTH - 1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
`ifdef FRAME_SCHED_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            if (last) begin
              frame_done <= 1'b1;
              state      <= (GAP == 0) ? IDLE : frame_sched_pkg::GAP;
              gap_cnt    <= '0;
              ptr        <= nxt_ptr;
            end
          end
`ifdef FRAME_SCHED_TIMEOUT_EN
          // Abort path: no frame_done, but the channel still loses its turn.
          else if (stall_cnt == SW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            stall_cnt   <= '0;
            state       <= (GAP == 0) ? IDLE : frame_sched_pkg::GAP;
            gap_cnt     <= '0;
            ptr         <= nxt_ptr;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
`endif
        end
        frame_sched_pkg::GAP: begin
          if (gap_cnt == GW'(GAP - 1)) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef FRAME_SCHED_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_write_scheduler.sv
// Directed bench for frame_write_scheduler: expected beats queued by stimulus, checked by a monitor.
module tb_frame_write_scheduler;
  localparam int WI = 32, WIDTH = 4, HEIGHT = 2, N_REQ = 4, GAP = 2, TIMEOUT = 8;
  localparam int TOTAL = WIDTH * HEIGHT;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]    req_valid, req_ready;
  logic [N_REQ*WI-1:0] req_data;
  logic                wr_vld, frame_start, frame_done, busy, timeout_err;
  logic [WI-1:0]       wr_data;
  logic [1:0]          wr_ch;
  logic [11:0]         wr_row, wr_col;

  frame_write_scheduler #(
    .WI(WI), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .N_REQ(N_REQ), .GAP(GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .wr_vld(wr_vld), .wr_data(wr_data), .wr_ch(wr_ch), .wr_row(wr_row), .wr_col(wr_col),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  ch;
    logic [11:0] row;
    logic [11:0] col;
    logic        done;
  } beat_t;

  beat_t q[$];
  beat_t got, e;
  int    sent[N_REQ];
  int    exp_sent[N_REQ];
  int    n_cmp = 0, n_bad = 0, starts = 0;

  function automatic logic [31:0] mk(input int ch, input int k);
    return {8'hA0, 8'(ch), 16'(k)};
  endfunction

  // Each channel presents a distinct word per beat it has handed over.
  always @(posedge clk)
    for (int i = 0; i < N_REQ; i++)
      if (req_valid[i] && req_ready[i]) sent[i] <= sent[i] + 1;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N_REQ; i++) req_data[i*WI +: WI] = mk(i, sent[i]);
  end

  always @(negedge clk) begin
    if (frame_start) starts++;
    if (wr_vld) begin
      n_cmp++;
      got = '{data: wr_data, ch: wr_ch, row: wr_row, col: wr_col, done: frame_done};
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat: got data=%h ch=%0d row=%0d col=%0d, want none",
                 wr_data, wr_ch, wr_row, wr_col);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL beat: got data=%h ch=%0d row=%0d col=%0d done=%0b, want data=%h ch=%0d row=%0d col=%0d done=%0b",
                   got.data, got.ch, got.row, got.col, got.done, e.data, e.ch, e.row, e.col, e.done);
        end
      end
    end else if (frame_done) begin
      n_cmp++; n_bad++;
      $display("FAIL stray_frame_done: got 1 without wr_vld, want 0");
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_beats(input int ch, input int first, input int n);
    beat_t b;
    for (int k = first; k < first + n; k++) begin
      b.data = mk(ch, exp_sent[ch]);
      exp_sent[ch]++;
      b.ch   = 2'(ch);
      b.row  = 12'(k / WIDTH);
      b.col  = 12'(k % WIDTH);
      b.done = (k == TOTAL - 1);
      q.push_back(b);
    end
  endtask

  task automatic wait_empty(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (q.size() == 0) return;
    end
    chk({name, "_drain_timeout"}, 64'(q.size()), 0);
  endtask

  task automatic wait_sent(input string name, input int ch, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (sent[ch] == target) return;
    end
    chk({name, "_sent_timeout"}, 64'(sent[ch]), 64'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    req_valid = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctl", {wr_vld, frame_start, frame_done, busy, timeout_err, req_ready, wr_ch}, 0);
    chk("reset_data", {wr_data, wr_row, wr_col}, 0);
    rstn = 1'b1;
    @(negedge clk); #1;

    // Channel 1 alone, back-to-back
    push_beats(1, 0, TOTAL);
    req_valid = 4'b0010;
    @(negedge clk); #1;
    chk("t1_start", {frame_start, busy, req_ready}, {1'b1, 1'b1, 4'b0010});
    wait_empty("t1", 40);
    chk("t1_gap0", {busy, req_ready}, 0);
    @(negedge clk); #1;
    chk("t1_gap1", {busy, req_ready}, 0);
    req_valid = '0;

    // Fresh pointer, then all channels contending
    rstn = 1'b0;
    @(negedge clk); #1;
    rstn = 1'b1;
    push_beats(0, 0, TOTAL); push_beats(1, 0, TOTAL); push_beats(2, 0, TOTAL);
    push_beats(3, 0, TOTAL); push_beats(0, 0, TOTAL);
    req_valid = 4'b1111;
    wait_empty("t2", 200);
    req_valid = '0;

    // Channel 2 stalls three cycles after beat 5
    push_beats(2, 0, TOTAL);
    base = sent[2];
    req_valid = 4'b0100;
    wait_sent("t3", 2, base + 5, 40);
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("t3_stall%0d", k), {wr_vld, busy}, 2'b01);
    end
    req_valid = 4'b0100;
    wait_empty("t3", 40);
    req_valid = '0;

    // Reset after beat 4 of channel 0; pointer was at 3, must restart from 0
    push_beats(0, 0, 4);
    base = sent[0];
    req_valid = 4'b0001;
    wait_sent("t4", 0, base + 4, 40);
    rstn = 1'b0;
    #1;
    chk("t4_reset_ctl", {wr_vld, frame_start, frame_done, busy, timeout_err, req_ready, wr_ch}, 0);
    chk("t4_reset_data", {wr_data, wr_row, wr_col}, 0);
    req_valid = 4'b1010;
    @(negedge clk); #1;
    chk("t4_reset_hold", {wr_vld, frame_done, busy, req_ready}, 0);
    rstn = 1'b1;
    push_beats(1, 0, TOTAL);
    wait_empty("t4", 40);
    req_valid = '0;

    // Channel 3 stalls after beat 2
    push_beats(3, 0, 2);
    base = sent[3];
    req_valid = 4'b1000;
    wait_sent("t5", 3, base + 2, 40);
    req_valid = '0;
`ifdef FRAME_SCHED_TIMEOUT_EN
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); #1;
      chk($sformatf("t5_terr_%0d", k), {timeout_err, busy}, {k == 8, k < 8});
    end
    push_beats(0, 0, TOTAL);
    req_valid = 4'b1001;
    wait_empty("t5", 40);
    req_valid = '0;
`else
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      chk($sformatf("t5_hold_%0d", k), {busy, timeout_err, wr_vld, req_ready}, {3'b100, 4'b1000});
    end
    push_beats(3, 2, TOTAL - 2);
    req_valid = 4'b1000;
    wait_empty("t5", 40);
    req_valid = '0;
`endif

    repeat (6) @(negedge clk);
    #1;
`ifdef FRAME_SCHED_TIMEOUT_EN
    chk("frame_starts", 64'(starts), 11);
`else
    chk("frame_starts", 64'(starts), 10);
`endif
    chk("queue_left", 64'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
